// File: rtl/BufferedRound.sv
// BufferedRound: forward AES round, thin wrapper over buffered_round.
// Ports: clock, reset (sync, active-high), in (state), key (round key), out (registered).
module BufferedRound #(
    parameter int unsigned ROUND      = 1,
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KEY_SIZE   = 128
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [127:0]        in,
    input  logic [KEY_SIZE-1:0] key,
    output logic [127:0]        out
);

    buffered_round #(
        .ROUND      (ROUND),
        .NUM_ROUNDS (NUM_ROUNDS),
        .KEY_SIZE   (KEY_SIZE),
        .INVERSE    (0)
    ) u_round (
        .clock (clock),
        .reset (reset),
        .in    (in),
        .key   (key),
        .out   (out)
    );

endmodule

// File: rtl/BufferedRoundInverse.sv
// BufferedRoundInverse: inverse AES round, thin wrapper over buffered_round.
// Ports: clock, reset (sync, active-high), in (state), key (round key), out (registered).
module BufferedRoundInverse #(
    parameter int unsigned ROUND      = 1,
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KEY_SIZE   = 128
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [127:0]        in,
    input  logic [KEY_SIZE-1:0] key,
    output logic [127:0]        out
);

    buffered_round #(
        .ROUND      (ROUND),
        .NUM_ROUNDS (NUM_ROUNDS),
        .KEY_SIZE   (KEY_SIZE),
        .INVERSE    (1)
    ) u_round (
        .clock (clock),
        .reset (reset),
        .in    (in),
        .key   (key),
        .out   (out)
    );

endmodule

// File: rtl/buffered_round.sv
// buffered_round: one AES-128 round (forward or inverse, normal or final) with
// a single output register. All transform logic is combinational, so each
// result appears one clock after its inputs and a new pair is taken every cycle.
//
// Parameters
//   ROUND      round index 1..NUM_ROUNDS; ROUND == NUM_ROUNDS drops (Inv)MixColumns
//   NUM_ROUNDS total round count (10 for AES-128)
//   KEY_SIZE   round-key width; the upper 128 bits are used
//   INVERSE    0 = forward round, 1 = inverse round
// Ports
//   clock  rising-edge clock
//   reset  synchronous active-high reset, clears out
//   in     128-bit state, byte 0 in [127:120], column-major
//   key    round key, same byte order as in
//   out    registered round result
module buffered_round #(
    parameter int unsigned ROUND      = 1,
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KEY_SIZE   = 128,
    parameter int unsigned INVERSE    = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [127:0]        in,
    input  logic [KEY_SIZE-1:0] key,
    output logic [127:0]        out
);

    localparam bit IsFinal = (ROUND == NUM_ROUNDS);

    // Byte 0x00 sits in the top 8 bits of each table.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        // 8 * (255 - x), so entry 0 is read from the top of the table
        sub_byte = SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] x);
        inv_sub_byte = INV_SBOX[{~x, 3'b000} +: 8];
    endfunction

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        for (int i = 0; i < 16; i++) begin
            sub_bytes[127-8*i -: 8] = sub_byte(s[127-8*i -: 8]);
        end
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        for (int i = 0; i < 16; i++) begin
            inv_sub_bytes[127-8*i -: 8] = inv_sub_byte(s[127-8*i -: 8]);
        end
    endfunction

    // Byte (row r, column c) lives at index 4*c + r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_rows[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                inv_shift_rows[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        mix_column[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        mix_column[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        mix_column[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        mix_column[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a   [4];
        logic [7:0] m9  [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]   = col[31-8*i -: 8];
            x2     = xtime(a[i]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m9[i]  = x8 ^ a[i];
            m11[i] = x8 ^ x2 ^ a[i];
            m13[i] = x8 ^ x4 ^ a[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        inv_mix_column[31:24] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
        inv_mix_column[23:16] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
        inv_mix_column[15:8]  = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
        inv_mix_column[7:0]   = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        for (int c = 0; c < 4; c++) begin
            mix_columns[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        for (int c = 0; c < 4; c++) begin
            inv_mix_columns[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
        end
    endfunction

    logic [127:0] round_key;
    logic [127:0] result;

    assign round_key = key[KEY_SIZE-1 -: 128];

    always_comb begin
        result = '0;
        if (INVERSE != 0) begin
            // Straightforward inverse cipher order: key is added before InvMixColumns.
            result = inv_sub_bytes(inv_shift_rows(in)) ^ round_key;
            if (!IsFinal) begin
                result = inv_mix_columns(result);
            end
        end else begin
            result = shift_rows(sub_bytes(in));
            if (!IsFinal) begin
                result = mix_columns(result);
            end
            result = result ^ round_key;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out <= '0;
        end else begin
            out <= result;
        end
    end

endmodule

// File: tb/tb_buffered_round.sv
// tb_buffered_round: drives five round variants (forward R1/R5/R10, inverse R1/R10)
// from shared in/key and compares each registered output against a reference
// model that derives the S-boxes from GF(2^8) inversion plus the affine map.
module tb_buffered_round;

    logic         clock;
    logic         reset;
    logic [127:0] din;
    logic [127:0] rkey;
    logic [127:0] out_f1, out_f5, out_f10, out_i1, out_i10;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sbox_t     [256];
    logic [7:0] inv_sbox_t [256];

    buffered_round #(.ROUND(1),  .NUM_ROUNDS(10), .KEY_SIZE(128), .INVERSE(0)) u_f1 (
        .clock(clock), .reset(reset), .in(din), .key(rkey), .out(out_f1));
    buffered_round #(.ROUND(5),  .NUM_ROUNDS(10), .KEY_SIZE(128), .INVERSE(0)) u_f5 (
        .clock(clock), .reset(reset), .in(din), .key(rkey), .out(out_f5));
    buffered_round #(.ROUND(10), .NUM_ROUNDS(10), .KEY_SIZE(128), .INVERSE(0)) u_f10 (
        .clock(clock), .reset(reset), .in(din), .key(rkey), .out(out_f10));
    buffered_round #(.ROUND(1),  .NUM_ROUNDS(10), .KEY_SIZE(128), .INVERSE(1)) u_i1 (
        .clock(clock), .reset(reset), .in(din), .key(rkey), .out(out_i1));
    buffered_round #(.ROUND(10), .NUM_ROUNDS(10), .KEY_SIZE(128), .INVERSE(1)) u_i10 (
        .clock(clock), .reset(reset), .in(din), .key(rkey), .out(out_i10));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_t[x] = s;
            inv_sbox_t[s] = 8'(x);
        end
    endtask

    // State as st[row][col]; byte index 4*col+row counted from the MSB.
    function automatic logic [127:0] model_round(input bit inverse, input bit fin,
                                                 input logic [127:0] d, input logic [127:0] k);
        logic [7:0] st [4][4];
        logic [7:0] t  [4][4];
        logic [7:0] m  [4][4];
        logic [7:0] coef [4];
        logic [127:0] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = d[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (inverse) t[r][c] = inv_sbox_t[st[r][(c-r+4)%4]] ^ k[127-8*(4*c+r) -: 8];
                else         t[r][c] = sbox_t[st[r][(c+r)%4]];
        if (inverse) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                m[r][c] = 8'h00;
                for (int j = 0; j < 4; j++) m[r][c] = m[r][c] ^ gmul(coef[(j-r+4)%4], t[j][c]);
                if (fin) m[r][c] = t[r][c];
            end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = m[r][c];
        if (!inverse) res = res ^ k;
        return res;
    endfunction

    // Apply one input set for one edge and check every instance just after that edge.
    task automatic step(input logic rst, input logic [127:0] d, input logic [127:0] k);
        @(negedge clock);
        reset = rst;
        din   = d;
        rkey  = k;
        @(posedge clock);
        #1;
        check("fwd_r1",  out_f1,  rst ? 128'h0 : model_round(1'b0, 1'b0, d, k));
        check("fwd_r5",  out_f5,  rst ? 128'h0 : model_round(1'b0, 1'b0, d, k));
        check("fwd_r10", out_f10, rst ? 128'h0 : model_round(1'b0, 1'b1, d, k));
        check("inv_r1",  out_i1,  rst ? 128'h0 : model_round(1'b1, 1'b0, d, k));
        check("inv_r10", out_i10, rst ? 128'h0 : model_round(1'b1, 1'b1, d, k));
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        reset = 1'b1;
        din   = '0;
        rkey  = '0;
        build_tables();

        // Reset held for two cycles with nonzero inputs.
        step(1'b1, rand128(), rand128());
        step(1'b1, 128'h0123456789abcdeffedcba9876543210, rand128());

        // Known-answer vectors, the first one right after reset release.
        step(1'b0, 128'h00102030405060708090a0b0c0d0e0f0, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        check("kat_fwd_r1", out_f1, 128'h89d810e8855ace682d1843d8cb128fe4);
        step(1'b0, 128'hbd6e7c3df2b5779e0b61216e8b10b689, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("kat_fwd_final", out_f10, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        step(1'b0, 128'h6353e08c0960e104cd70b751bacad0e7, 128'h000102030405060708090a0b0c0d0e0f);
        check("kat_inv_final", out_i10, 128'h00112233445566778899aabbccddeeff);
        step(1'b0, 128'h0, 128'h0);
        check("zero_fwd", out_f1, {16{8'h63}});
        check("zero_inv", out_i1, {16{8'h52}});

        // Mid-stream reset, then recovery.
        step(1'b1, rand128(), rand128());
        step(1'b0, rand128(), rand128());

        // Back-to-back random stream with occasional reset pulses.
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 19) == 0), rand128(), rand128());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/buffered_round.md
BUFFERED_ROUND -- requirements
Module: buffered_round

Interface
REQ-001 Parameter ROUND, default 1: round index 1..NUM_ROUNDS; ROUND == NUM_ROUNDS selects the final-round variant.
REQ-002 Parameter NUM_ROUNDS, default 10: AES-128 round count.
REQ-003 Parameter KEY_SIZE, default 128: round-key width.
REQ-004 Parameter INVERSE, default 0: 0 gives the forward round (BufferedRound); 1 gives the inverse round (BufferedRoundInverse).
REQ-005 Wrapper modules BufferedRound and BufferedRoundInverse SHALL instantiate buffered_round with INVERSE=0 and INVERSE=1, pass ROUND through as their first parameter, and use port order (clock, reset, in, key, out).
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in  input  128  AES state; byte 0 = in[127:120], FIPS-197 column-major (bytes 0..3 form column 0).
REQ-009 key  input  KEY_SIZE  round key, same byte order as in.
REQ-010 out  output  128  registered round result.

Function
REQ-011 The forward non-final round SHALL compute out = AddRoundKey(MixColumns(ShiftRows(SubBytes(in))), key).
REQ-012 The forward final round (ROUND == NUM_ROUNDS) SHALL omit MixColumns: out = ShiftRows(SubBytes(in)) ^ key.
REQ-013 The inverse non-final round SHALL compute out = InvMixColumns(InvSubBytes(InvShiftRows(in)) ^ key), following the FIPS-197 straightforward inverse-cipher order.
REQ-014 The inverse final round (ROUND == NUM_ROUNDS) SHALL omit InvMixColumns: out = InvSubBytes(InvShiftRows(in)) ^ key.
REQ-015 SubBytes and InvSubBytes SHALL use the FIPS-197 S-box and inverse S-box as combinational constant tables.
REQ-016 MixColumns SHALL use GF(2^8) polynomial 0x11B with matrix {02,03,01,01} rotated per row; InvMixColumns SHALL use {0e,0b,0d,09}.
REQ-017 ShiftRows SHALL rotate row r left by r bytes; InvShiftRows SHALL rotate row r right by r bytes.
REQ-018 All transform logic SHALL be combinational, with exactly one output register; latency is 1 cycle and there are no bubbles.
REQ-019 A new in/key pair is accepted every cycle; out at edge N+1 reflects in/key sampled at edge N.
REQ-020 No handshake, valid flag or internal state SHALL exist beyond the out register.
REQ-021 ROUND values other than NUM_ROUNDS SHALL all produce identical non-final behaviour.

Reset
REQ-022 When reset is high at a rising edge, out SHALL become 128'h0, regardless of in and key.
REQ-023 Reset asserted mid-stream SHALL discard the pending result, and out SHALL hold 0 for every cycle reset stays high.
REQ-024 On the first edge after reset deasserts, out SHALL load the round result of the inputs present at that edge.

Verification
REQ-025 Forward, ROUND=1: in=00102030405060708090A0B0C0D0E0F0, key=D6AA74FDD2AF72FADAA678F1D6AB76FE -> out=89D810E8855ACE682D1843D8CB128FE4 one cycle later.
REQ-026 Forward final, ROUND=10: in=BD6E7C3DF2B5779E0B61216E8B10B689, key=13111D7FE3944A17F307A78B4D2B30C5 -> out=69C4E0D86A7B0430D8CDB78070B4C55A.
REQ-027 Inverse final, ROUND=10: in=6353E08C0960E104CD70B751BACAD0E7, key=000102030405060708090A0B0C0D0E0F -> out=00112233445566778899AABBCCDDEEFF.
REQ-028 Zero input, non-final: in=0, key=0 -> forward out = 63 repeated in all 16 bytes; inverse out = 52 repeated in all 16 bytes.
REQ-029 Reset: hold reset for 2 cycles with nonzero in -> out=0 throughout; deassert -> the correct result appears one cycle later; reasserting reset mid-stream -> out=0 at the next edge.
REQ-030 Back-to-back streaming: apply a different vector every cycle -> each result appears exactly one cycle after its input, with none dropped or duplicated.
